// File: rtl/ps2_scancode_decoder.sv
// ---------------------------------------------------------------------------------------------
// ps2_scancode_decoder
//
// Turns the raw byte stream of a PS/2 keyboard into key events. A parser FSM folds the E0/F0/E1
// prefixes into one {extended, release, code} event per key action. Events go into a small
// first-word-fall-through FIFO that the consumer pops with i_ack.
//
// Optional build macro: PS2_MODIFIER_TRACK_EN
//   Defined   -> o_mods follows shift/ctrl/alt/caps-lock state from every decoded event.
//   Undefined -> o_mods is tied to zero and no tracking logic is built.
//
// Parameters
//   FIFO_DEPTH  event FIFO depth in entries (power of two, >= 2)
//
// Ports
//   i_clk       system clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_data      received byte from the PS/2 host driver
//   i_ready     one-cycle strobe, i_data valid
//   i_error     one-cycle strobe, driver frame/timeout error
//   i_ack       pop the FIFO head (ignored while o_valid is low)
//   o_valid     FIFO non-empty
//   o_code      head event scancode
//   o_release   head event is a break (key up)
//   o_extended  head event carried an E0/E1 prefix
//   o_overflow  one-cycle pulse when an event is dropped on a full FIFO
//   o_mods      {caps_lock, alt, ctrl, shift}
// ---------------------------------------------------------------------------------------------
module ps2_scancode_decoder #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_ready,
  input  logic       i_error,
  input  logic       i_ack,
  output logic       o_valid,
  output logic [7:0] o_code,
  output logic       o_release,
  output logic       o_extended,
  output logic       o_overflow,
  output logic [3:0] o_mods
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  // Protocol bytes
  localparam logic [7:0] ByteExt   = 8'hE0;
  localparam logic [7:0] ByteBrk   = 8'hF0;
  localparam logic [7:0] BytePause = 8'hE1;

  typedef enum logic [2:0] {
    StIdle,
    StExt,
    StBrk,
    StExtBrk,
    StPause
  } state_e;

  state_e     r_state, w_state_nxt;
  logic [2:0] r_skip, w_skip_nxt;

  logic       w_push;
  logic       w_ev_ext;
  logic       w_ev_rel;
  logic [7:0] w_ev_code;
  logic       w_discard;

  // ---------------------------------------------------------------------------
  // Parser
  // ---------------------------------------------------------------------------

  // Keyboard status/response bytes that never form key events when seen on their own.
  always_comb begin
    w_discard = 1'b0;
    case (i_data)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: w_discard = 1'b1;
      default:                                                  w_discard = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_skip_nxt  = r_skip;
    w_push      = 1'b0;
    w_ev_ext    = 1'b0;
    w_ev_rel    = 1'b0;
    w_ev_code   = i_data;

    if (i_error) begin
      // Error wins over a same-cycle byte; any partial prefix is thrown away.
      w_state_nxt = StIdle;
      w_skip_nxt  = 3'd0;
    end else if (i_ready) begin
      case (r_state)
        StIdle: begin
          if (i_data == ByteExt) begin
            w_state_nxt = StExt;
          end else if (i_data == ByteBrk) begin
            w_state_nxt = StBrk;
          end else if (i_data == BytePause) begin
            // E1 is followed by 7 more bytes that carry no further information.
            w_state_nxt = StPause;
            w_skip_nxt  = 3'd7;
          end else if (!w_discard) begin
            w_push = 1'b1;
          end
        end
        StExt: begin
          if (i_data == ByteBrk) begin
            w_state_nxt = StExtBrk;
          end else begin
            w_push      = 1'b1;
            w_ev_ext    = 1'b1;
            w_state_nxt = StIdle;
          end
        end
        StBrk: begin
          w_push      = 1'b1;
          w_ev_rel    = 1'b1;
          w_state_nxt = StIdle;
        end
        StExtBrk: begin
          w_push      = 1'b1;
          w_ev_ext    = 1'b1;
          w_ev_rel    = 1'b1;
          w_state_nxt = StIdle;
        end
        StPause: begin
          w_skip_nxt = r_skip - 3'd1;
          if (r_skip == 3'd1) begin
            w_push      = 1'b1;
            w_ev_ext    = 1'b1;
            w_ev_code   = BytePause;
            w_state_nxt = StIdle;
          end
        end
        default: begin
          w_state_nxt = StIdle;
          w_skip_nxt  = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_skip  <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_skip  <= w_skip_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------

  // Entry layout: {extended, release, code}
  logic [9:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic        r_overflow;

  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_wr;
  logic        w_drop;
  logic [9:0]  w_head;

  // The extra pointer MSB separates full (MSBs differ) from empty (MSBs equal).
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = i_ack && !w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 10'd0;
      end
    end else if (w_wr) begin
      r_mem[r_wptr[AW-1:0]] <= {w_ev_ext, w_ev_rel, w_ev_code};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + PtrOne;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PtrOne;
      end
      r_overflow <= w_drop;
    end
  end

  assign w_head     = w_empty ? 10'd0 : r_mem[r_rptr[AW-1:0]];
  assign o_valid    = !w_empty;
  assign o_extended = w_head[9];
  assign o_release  = w_head[8];
  assign o_code     = w_head[7:0];
  assign o_overflow = r_overflow;

  // ---------------------------------------------------------------------------
  // Modifier tracking
  // ---------------------------------------------------------------------------
`ifdef PS2_MODIFIER_TRACK_EN
  localparam logic [7:0] CodeLShift = 8'h12;
  localparam logic [7:0] CodeRShift = 8'h59;
  localparam logic [7:0] CodeCtrl   = 8'h14;
  localparam logic [7:0] CodeAlt    = 8'h11;
  localparam logic [7:0] CodeCaps   = 8'h58;

  logic r_lshift, r_rshift, r_lctrl, r_rctrl, r_lalt, r_ralt, r_caps;
  logic w_make;

  assign w_make = !w_ev_rel;

  // Follows decoded events even when the FIFO drops them, so held-key state never desyncs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lshift <= 1'b0;
      r_rshift <= 1'b0;
      r_lctrl  <= 1'b0;
      r_rctrl  <= 1'b0;
      r_lalt   <= 1'b0;
      r_ralt   <= 1'b0;
      r_caps   <= 1'b0;
    end else if (w_push) begin
      if (!w_ev_ext && w_ev_code == CodeLShift) r_lshift <= w_make;
      if (!w_ev_ext && w_ev_code == CodeRShift) r_rshift <= w_make;
      if (!w_ev_ext && w_ev_code == CodeCtrl)   r_lctrl  <= w_make;
      if (w_ev_ext  && w_ev_code == CodeCtrl)   r_rctrl  <= w_make;
      if (!w_ev_ext && w_ev_code == CodeAlt)    r_lalt   <= w_make;
      if (w_ev_ext  && w_ev_code == CodeAlt)    r_ralt   <= w_make;
      // Typematic repeats are makes too, so each one toggles.
      if (!w_ev_ext && w_make && w_ev_code == CodeCaps) r_caps <= !r_caps;
    end
  end

  assign o_mods = {r_caps, r_lalt | r_ralt, r_lctrl | r_rctrl, r_lshift | r_rshift};
`else
  assign o_mods = 4'd0;
`endif

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// ---------------------------------------------------------------------------------------------
// tb_ps2_scancode_decoder
//
// Table-driven bench for ps2_scancode_decoder. Each table row drives one cycle of inputs and
// states whether that cycle completes an event, which event, and the modifier state after it.
// Expected events go to a scoreboard queue when driven and are compared against the FIFO head
// every cycle; a queue-occupancy model predicts overflow pulses. Reset is checked by hand.
// ---------------------------------------------------------------------------------------------
module tb_ps2_scancode_decoder;

  localparam int unsigned Depth = 4;
`ifdef PS2_MODIFIER_TRACK_EN
  localparam bit Trk = 1'b1;
`else
  localparam bit Trk = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       i_rst_n;
  logic [7:0] i_data;
  logic       i_ready;
  logic       i_error;
  logic       i_ack;
  logic       o_valid;
  logic [7:0] o_code;
  logic       o_release;
  logic       o_extended;
  logic       o_overflow;
  logic [3:0] o_mods;

  always #5 clk = ~clk;

  ps2_scancode_decoder #(
    .FIFO_DEPTH(Depth)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (i_rst_n),
    .i_data    (i_data),
    .i_ready   (i_ready),
    .i_error   (i_error),
    .i_ack     (i_ack),
    .o_valid   (o_valid),
    .o_code    (o_code),
    .o_release (o_release),
    .o_extended(o_extended),
    .o_overflow(o_overflow),
    .o_mods    (o_mods)
  );

  typedef struct {
    logic [7:0] data;
    logic       rdy;
    logic       err;
    logic       ack;
    logic       push;  // this cycle completes an event
    logic [9:0] ev;    // {ext, rel, code}
    logic [3:0] mods;  // o_mods expected after this cycle
  } vec_t;

  vec_t       tbl[$];
  logic [9:0] sb_q[$];
  logic       m_ovf;
  logic [3:0] m_mods;
  int         n_checks;
  int         n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] mm(input logic [3:0] v);
    return Trk ? v : 4'h0;
  endfunction

  function automatic vec_t mk(input logic [7:0] d, input logic rdy, input logic err,
                              input logic ack, input logic push, input logic [9:0] ev,
                              input logic [3:0] mods);
    vec_t v;
    v.data = d;
    v.rdy  = rdy;
    v.err  = err;
    v.ack  = ack;
    v.push = push;
    v.ev   = ev;
    v.mods = mods;
    return v;
  endfunction

  // Byte with no event expected / byte completing event ev.
  task automatic b(input logic [7:0] d, input logic ack, input logic [3:0] mods);
    tbl.push_back(mk(d, 1'b1, 1'b0, ack, 1'b0, 10'h0, mods));
  endtask
  task automatic e(input logic [7:0] d, input logic ack, input logic [9:0] ev,
                   input logic [3:0] mods);
    tbl.push_back(mk(d, 1'b1, 1'b0, ack, 1'b1, ev, mods));
  endtask
  task automatic idle(input logic ack, input logic [3:0] mods);
    tbl.push_back(mk(8'h1C, 1'b0, 1'b0, ack, 1'b0, 10'h0, mods));
  endtask

  // One clock: compare outputs against the model mid-cycle, then advance the model past the edge.
  task automatic step(input logic push, input logic [9:0] ev, input logic [3:0] mods_nxt);
    logic exp_valid;
    logic pop;
    @(negedge clk);
    exp_valid = (sb_q.size() != 0);
    check("o_valid", {31'd0, o_valid}, {31'd0, exp_valid});
    if (exp_valid) check("head", {22'd0, o_extended, o_release, o_code}, {22'd0, sb_q[0]});
    check("o_overflow", {31'd0, o_overflow}, {31'd0, m_ovf});
    check("o_mods", {28'd0, o_mods}, {28'd0, m_mods});
    pop = i_ack && exp_valid;
    @(posedge clk);
    #1;
    m_ovf = 1'b0;
    if (pop) void'(sb_q.pop_front());
    if (push) begin
      if (sb_q.size() >= Depth) m_ovf = 1'b1;
      else sb_q.push_back(ev);
    end
    m_mods = mods_nxt;
  endtask

  task automatic apply(input vec_t v);
    i_data  = v.data;
    i_ready = v.rdy;
    i_error = v.err;
    i_ack   = v.ack;
    step(v.push, v.ev, v.mods);
    i_ready = 1'b0;
    i_error = 1'b0;
  endtask

  initial begin
    i_rst_n  = 1'b0;
    i_data   = 8'h00;
    i_ready  = 1'b0;
    i_error  = 1'b0;
    i_ack    = 1'b0;
    m_ovf    = 1'b0;
    m_mods   = 4'h0;
    n_checks = 0;
    n_fail   = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst o_valid", {31'd0, o_valid}, 32'd0);
    check("rst o_code", {24'd0, o_code}, 32'd0);
    check("rst o_release", {31'd0, o_release}, 32'd0);
    check("rst o_extended", {31'd0, o_extended}, 32'd0);
    check("rst o_overflow", {31'd0, o_overflow}, 32'd0);
    check("rst o_mods", {28'd0, o_mods}, 32'd0);
    i_rst_n = 1'b1;

    // ---- main decode table (ack held high) ----
    e(8'h1C, 1, 10'h01C, 0);  b(8'hF0, 1, 0); e(8'h1C, 1, 10'h11C, 0); idle(1, 0);
    b(8'hE0, 1, 0); e(8'h75, 1, 10'h275, 0);
    b(8'hE0, 1, 0); b(8'hF0, 1, 0); e(8'h75, 1, 10'h375, 0);
    // Pause: 8 bytes, one event
    b(8'hE1, 1, 0); b(8'h14, 1, 0); b(8'h77, 1, 0); b(8'hE1, 1, 0);
    b(8'hF0, 1, 0); b(8'h14, 1, 0); b(8'hF0, 1, 0); e(8'h77, 1, 10'h2E1, 0);
    // Status bytes in IDLE are dropped
    b(8'hAA, 1, 0); b(8'hFA, 1, 0); b(8'h00, 1, 0); b(8'hFF, 1, 0); idle(1, 0);
    // Data without i_ready is ignored
    tbl.push_back(mk(8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h0, 4'h0));
    e(8'h1C, 1, 10'h01C, 0);
    // Error abandons a prefix and wins over a same-cycle byte
    b(8'hE0, 1, 0);
    tbl.push_back(mk(8'h1C, 1'b1, 1'b1, 1'b1, 1'b0, 10'h0, 4'h0));
    e(8'h1C, 1, 10'h01C, 0);
    b(8'hF0, 1, 0);
    tbl.push_back(mk(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 10'h0, 4'h0));
    e(8'h1C, 1, 10'h01C, 0);
    // Push and pop together with one entry held
    e(8'h1B, 1, 10'h01B, 0); e(8'h1B, 1, 10'h01B, 0); idle(1, 0); idle(1, 0);
    // ---- overflow: four fill, fifth dropped, then push+pop while full ----
    e(8'h15, 0, 10'h015, 0); e(8'h16, 0, 10'h016, 0); e(8'h1D, 0, 10'h01D, 0);
    e(8'h24, 0, 10'h024, 0); e(8'h2D, 0, 10'h02D, 0);
    e(8'h35, 1, 10'h035, 0); idle(0, 0);
    for (int i = 0; i < 6; i++) idle(1, 0);
    // ---- modifiers (expected zero when tracking is not built) ----
    e(8'h12, 1, 10'h012, mm(4'h1)); e(8'h59, 1, 10'h059, mm(4'h1));
    b(8'hF0, 1, mm(4'h1)); e(8'h12, 1, 10'h112, mm(4'h1));
    b(8'hF0, 1, mm(4'h1)); e(8'h59, 1, 10'h159, mm(4'h0));
    e(8'h58, 1, 10'h058, mm(4'h8)); b(8'hF0, 1, mm(4'h8)); e(8'h58, 1, 10'h158, mm(4'h8));
    e(8'h58, 1, 10'h058, mm(4'h0));
    b(8'hE0, 1, 0); e(8'h14, 1, 10'h214, mm(4'h2));
    b(8'hE0, 1, mm(4'h2)); b(8'hF0, 1, mm(4'h2)); e(8'h14, 1, 10'h314, mm(4'h0));
    e(8'h14, 1, 10'h014, mm(4'h2)); b(8'hF0, 1, mm(4'h2)); e(8'h14, 1, 10'h114, mm(4'h0));
    e(8'h11, 1, 10'h011, mm(4'h4)); b(8'hE0, 1, mm(4'h4)); e(8'h11, 1, 10'h211, mm(4'h4));
    b(8'hF0, 1, mm(4'h4)); e(8'h11, 1, 10'h111, mm(4'h4));
    b(8'hE0, 1, mm(4'h4)); b(8'hF0, 1, mm(4'h4)); e(8'h11, 1, 10'h311, mm(4'h0));
    idle(1, 0); idle(1, 0);

    foreach (tbl[i]) apply(tbl[i]);

    // ---- reset mid-sequence: held event and F0 prefix both discarded ----
    tbl.delete();
    apply(mk(8'h1C, 1'b1, 1'b0, 1'b0, 1'b1, 10'h01C, 4'h0));
    apply(mk(8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h0, 4'h0));
    i_rst_n = 1'b0;
    #1;
    check("async rst o_valid", {31'd0, o_valid}, 32'd0);
    check("async rst o_code", {24'd0, o_code}, 32'd0);
    check("async rst o_overflow", {31'd0, o_overflow}, 32'd0);
    check("async rst o_mods", {28'd0, o_mods}, 32'd0);
    sb_q.delete();
    m_ovf  = 1'b0;
    m_mods = 4'h0;
    @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    apply(mk(8'h1C, 1'b1, 1'b0, 1'b1, 1'b1, 10'h01C, 4'h0));
    apply(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 10'h0, 4'h0));
    apply(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 10'h0, 4'h0));
    check("scoreboard drained", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, the event FIFO depth in entries, a power of two and at least 2.
REQ-002 The block SHALL have port i_clk, input, 1 bit, the single system clock; all logic on its rising edge.
REQ-003 The block SHALL have port i_rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-004 The block SHALL have port i_data, input, 8 bits, the received byte from the PS/2 host driver.
REQ-005 The block SHALL have port i_ready, input, 1 bit, a one-cycle strobe marking i_data valid.
REQ-006 The block SHALL have port i_error, input, 1 bit, a one-cycle strobe marking a driver frame or timeout error.
REQ-007 The block SHALL have port i_ack, input, 1 bit, the consumer pop of the FIFO head; ignored when o_valid=0.
REQ-008 The block SHALL have port o_valid, output, 1 bit, high while the FIFO is non-empty.
REQ-009 The block SHALL have port o_code, output, 8 bits, the head event scancode.
REQ-010 The block SHALL have port o_release, output, 1 bit, set when the head event is a break (key up).
REQ-011 The block SHALL have port o_extended, output, 1 bit, set when the head event carried an E0 (or E1) prefix.
REQ-012 The block SHALL have port o_overflow, output, 1 bit, a one-cycle pulse when an event is dropped because the FIFO is full.
REQ-013 The block SHALL have port o_mods, output, 4 bits: {caps_lock, alt, ctrl, shift}.

Function
REQ-014 Bytes SHALL be consumed only in cycles where i_ready=1; i_data is ignored otherwise.
REQ-015 The parser FSM SHALL have states IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen) and PAUSE.
REQ-016 In IDLE: E0 -> EXT; F0 -> BRK; E1 -> PAUSE with the skip counter set to 7; 00, AA, EE, FA, FC, FD, FE, FF -> discarded, no event, stay IDLE; any other byte -> push {ext=0, rel=0, code}.
REQ-017 In EXT: F0 -> EXT_BRK; any other byte -> push {1, 0, code}, go to IDLE.
REQ-018 In BRK, any byte SHALL push {0, 1, code} and go to IDLE; in EXT_BRK, any byte SHALL push {1, 1, code} and go to IDLE.
REQ-019 In PAUSE, each byte SHALL decrement the 3-bit skip counter; on the byte that brings it to 0, the block SHALL push {1, 0, E1} and go to IDLE (8-byte Pause sequence gives exactly one event).
REQ-020 i_error SHALL force the FSM to IDLE and abandon any partial sequence with no event; i_error has priority over a same-cycle i_ready.
REQ-021 A pushed event SHALL appear at the FIFO with o_valid high on the cycle after the i_ready that completed it (1-cycle latency into an empty FIFO).
REQ-022 The FIFO SHALL be first-word-fall-through; o_code, o_release and o_extended SHALL reflect the head entry whenever o_valid=1.
REQ-023 i_ack with o_valid=1 SHALL pop the head in that cycle.
REQ-024 A push into a full FIFO with no same-cycle pop SHALL drop the new event, leave contents unchanged and pulse o_overflow.
REQ-025 A simultaneous push and pop SHALL keep the occupancy constant, including when full (no overflow) and when holding one entry.
REQ-026 Read and write pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished with an extra pointer bit.

Reset
REQ-027 Asserting i_rst_n low SHALL immediately do all of the following: FSM -> IDLE; skip counter, pointers and FIFO contents -> 0; o_valid, o_code, o_release, o_extended, o_overflow and o_mods -> 0.
REQ-028 A reset mid-sequence SHALL discard the partial prefix state; the first byte after reset is parsed from IDLE.

Configuration
REQ-029 With macro PS2_MODIFIER_TRACK_EN defined, o_mods SHALL track every decoded event, whether or not it is accepted into the FIFO.
REQ-030 Under PS2_MODIFIER_TRACK_EN, shift SHALL be set while L-shift 12 or R-shift 59 is held (non-extended); left and right are tracked separately and ORed.
REQ-031 Under PS2_MODIFIER_TRACK_EN, ctrl SHALL be set while L-ctrl 14 (non-extended) or R-ctrl 14 (extended) is held.
REQ-032 Under PS2_MODIFIER_TRACK_EN, alt SHALL be set while L-alt 11 (non-extended) or R-alt 11 (extended) is held.
REQ-033 Under PS2_MODIFIER_TRACK_EN, caps_lock SHALL toggle on each non-extended make of 58; typematic repeats toggle it again.
REQ-034 Under PS2_MODIFIER_TRACK_EN, o_mods SHALL update on the cycle after the completing byte.
REQ-035 Without PS2_MODIFIER_TRACK_EN, o_mods SHALL be constant 0 and no tracking logic SHALL be built.

Verification
REQ-036 Bytes 1C, then F0 1C, with i_ack held high -> events {0,0,1C} then {0,1,1C}, each o_valid for 1 cycle.
REQ-037 Bytes E0 75, then E0 F0 75 -> events {1,0,75} then {1,1,75}.
REQ-038 Bytes E1 14 77 E1 F0 14 F0 77 -> exactly one event {1,0,E1}; AA and FA in IDLE -> no event.
REQ-039 FIFO_DEPTH=4 and i_ack=0; five make codes -> 4 entries held, o_overflow pulses once on the 5th; pop order equals arrival order.
REQ-040 Byte E0, then an i_error pulse, then 1C -> event {0,0,1C}; i_rst_n low after F0 -> next byte 1C gives {0,0,1C}.
REQ-041 With PS2_MODIFIER_TRACK_EN: 12, 59, F0 12 -> shift stays 1; then F0 59 -> shift 0; 58, F0 58, 58 -> caps_lock 1, 1, 0.
